// File: rtl/gray_code_counter_pkg.sv
// rtl/gray_code_counter_pkg.sv - shared width default and binary-to-Gray encode helper
package gray_code_counter_pkg;

    localparam int GCC_DEFAULT_WIDTH = 8;
    localparam int GCC_MAX_WIDTH     = 64;

    // Zero-extended input keeps the top bit as-is, so this serves any width up to 64.
    function automatic logic [GCC_MAX_WIDTH-1:0] bin2gray(input logic [GCC_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_code_counter_if.sv
// rtl/gray_code_counter_if.sv - control and count bundle of the Gray code counter
interface gray_code_counter_if
    import gray_code_counter_pkg::*;
#(
    parameter int WIDTH = GCC_DEFAULT_WIDTH
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  bin, gray, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output bin, gray, wrap
    );
endinterface

// File: rtl/gray_code_counter_binary_to_gray.sv
// rtl/gray_code_counter_binary_to_gray.sv - combinational binary-to-Gray encoder
module binary_to_gray #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_code_counter.sv
// rtl/gray_code_counter.sv - up/down binary counter with registered Gray output and wrap pulse
module gray_code_counter
    import gray_code_counter_pkg::*;
#(
    parameter int WIDTH = GCC_DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    gray_code_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_q;
    logic             wrap_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            bin_d = bus.load_val;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                bin_d  = bin_q + ONE;
                wrap_d = (bin_q == ALL_ONES);
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = (bin_q == ZERO);
            end
        end
    end

    // Encoding the next-state value lets gray come straight off a flop, never off decode logic.
    binary_to_gray #(
        .WIDTH (WIDTH)
    ) u_enc (
        .bin  (bin_d),
        .gray (gray_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= ZERO;
            gray_q <= ZERO;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.bin  = bin_q;
    assign bus.gray = gray_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// tb/tb_gray_code_counter.sv - self-checking bench for gray_code_counter
module tb_gray_code_counter;
    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;
    int m_bin  = 0;
    int m_wrap = 0;

    gray_code_counter_if #(.WIDTH(W)) bus ();

    gray_code_counter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int enc(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int dec(input int g);
        int b = 0;
        for (int i = W - 1; i >= 0; i--) begin
            b[i] = g[i] ^ ((i == W - 1) ? 1'b0 : b[i + 1]);
        end
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_bin"},  32'(bus.bin),  32'(m_bin));
        check({tag, "_gray"}, 32'(bus.gray), 32'(enc(m_bin)));
        check({tag, "_wrap"}, 32'(bus.wrap), 32'(m_wrap));
    endtask

    task automatic cycle(input string tag);
        int nb;
        int nw;
        nb = m_bin;
        nw = 0;
        if (bus.load) begin
            nb = int'(bus.load_val);
        end else if (bus.en) begin
            if (bus.up_dn) begin
                nw = (m_bin == MAXV) ? 1 : 0;
                nb = (m_bin + 1) % (MAXV + 1);
            end else begin
                nw = (m_bin == 0) ? 1 : 0;
                nb = (m_bin + MAXV) % (MAXV + 1);
            end
        end
        @(posedge clk);
        #1;
        m_bin  = nb;
        m_wrap = nw;
        check_model(tag);
    endtask

    task automatic drive(input logic l, input int lv, input logic e, input logic u);
        bus.load     = l;
        bus.load_val = W'(lv);
        bus.en       = e;
        bus.up_dn    = u;
    endtask

    int load_in  [5] = '{160, 255, 111, 123, 10};
    int load_exp [5] = '{240, 128,  88,  70, 15};
    int up_bin   [3] = '{255, 0, 1};
    int up_gray  [3] = '{128, 0, 1};
    int dn_bin   [3] = '{0, 255, 254};
    int dn_gray  [3] = '{0, 128, 129};
    int wr_exp   [3] = '{0, 1, 0};

    initial begin
        logic [W-1:0] prev_g;
        logic [W-1:0] prev_b;
        rst = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_model("reset");

        rst = 1'b0;
        drive(1'b1, 8'h59, 1'b0, 1'b0);
        cycle("pre_load");
        drive(1'b0, 0, 1'b1, 1'b1);
        cycle("to_5a");
        check("at_5a", 32'(bus.bin), 32'h5A);
        #2;
        rst = 1'b1;
        #1;
        m_bin  = 0;
        m_wrap = 0;
        check_model("async_rst");
        @(posedge clk);
        #2;
        check_model("rst_held");
        rst = 1'b0;
        cycle("first_after_rst");
        check("first_bin", 32'(bus.bin), 32'd1);
        check("first_gray", 32'(bus.gray), 32'd1);

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, load_in[i], 1'b0, 1'b0);
            cycle("load");
            check("load_gray", 32'(bus.gray), 32'(load_exp[i]));
            check("load_wrap", 32'(bus.wrap), 32'd0);
        end

        drive(1'b1, 254, 1'b0, 1'b0);
        cycle("load254");
        drive(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle("up_wrap");
            check("upw_bin", 32'(bus.bin), 32'(up_bin[i]));
            check("upw_gray", 32'(bus.gray), 32'(up_gray[i]));
            check("upw_wrap", 32'(bus.wrap), 32'(wr_exp[i]));
        end

        drive(1'b1, 1, 1'b0, 1'b0);
        cycle("load1");
        drive(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("dn_wrap");
            check("dnw_bin", 32'(bus.bin), 32'(dn_bin[i]));
            check("dnw_gray", 32'(bus.gray), 32'(dn_gray[i]));
            check("dnw_wrap", 32'(bus.wrap), 32'(wr_exp[i]));
        end

        drive(1'b1, 0, 1'b0, 1'b0);
        cycle("load0");
        drive(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 512; i++) begin
            prev_g = bus.gray;
            prev_b = bus.bin;
            cycle("sweep");
            check("sweep_onebit", 32'($countones(bus.gray ^ prev_g)), 32'd1);
            check("sweep_roundtrip", 32'(dec(int'(bus.gray))), 32'(m_bin));
            if (prev_b == 8'd127) begin
                check("sweep_127_gray", 32'(prev_g), 32'd64);
                check("sweep_128_gray", 32'(bus.gray), 32'd192);
            end
        end

        drive(1'b1, 77, 1'b1, 1'b1);
        cycle("prio");
        check("prio_bin", 32'(bus.bin), 32'd77);
        check("prio_gray", 32'(bus.gray), 32'd107);
        check("prio_wrap", 32'(bus.wrap), 32'd0);
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle("hold");
            check("hold_bin", 32'(bus.bin), 32'd77);
            check("hold_gray", 32'(bus.gray), 32'd107);
        end

        for (int i = 0; i < 400; i++) begin
            logic l;
            logic e;
            l = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 3) != 0);
            drive(l, int'($urandom_range(0, MAXV)), e, 1'($urandom));
            if (($urandom_range(0, 9) == 0) && !l) begin
                bus.load_val = (($urandom & 1) != 0) ? W'(MAXV) : W'(0);
            end
            prev_g = bus.gray;
            cycle("rand");
            if (!l && e) begin
                check("rand_onebit", 32'($countones(bus.gray ^ prev_g)), 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
